// File: rtl/fifo_pkg.sv
// Definitions shared by the async FIFO read-side logic: default widths, the word
// type and the legal read-latency values.
package fifo_pkg;

    localparam int FIFO_DATASIZE = 8;
    localparam int FIFO_ADDRSIZE = 4;

    localparam int RD_LAT_COMB = 0;   // rdata shows the head word while not empty
    localparam int RD_LAT_REG  = 1;   // rdata valid the cycle after rinc

    typedef logic [FIFO_DATASIZE-1:0] fifo_word_t;

endpackage

// File: rtl/fifo_rd_skidbuf.sv
// Small circular output buffer for the FIFO read stream. The head word comes
// straight from storage, so the output is driven only from registered state.
module fifo_rd_skidbuf
    import fifo_pkg::*;
#(
    parameter int  DATASIZE  = FIFO_DATASIZE,
    parameter int  BUF_DEPTH = 2,
    localparam int AW        = $clog2(BUF_DEPTH),
    localparam int OW        = AW + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [DATASIZE-1:0] wr_data,
    input  logic                rd_en,
    output logic [DATASIZE-1:0] rd_data,
    output logic [OW-1:0]       occ
);

    logic [DATASIZE-1:0] mem_q [BUF_DEPTH];
    logic [DATASIZE-1:0] mem_d [BUF_DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]       occ_q, occ_d;
    logic                do_rd;

    assign do_rd = rd_en & (occ_q != '0);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        // write and read together leave the occupancy unchanged
        case ({wr_en, do_rd})
            2'b10:   occ_d = occ_q + OW'(1);
            2'b01:   occ_d = occ_q - OW'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign occ     = occ_q;

    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        !(wr_en && !do_rd && (occ_q == OW'(BUF_DEPTH))));

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO read-side drain engine: pops the FIFO into a small buffer and presents the
// words as a valid/ready stream. Define FIFO_RD_STATS_EN for pop/stall counters.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int DATASIZE   = FIFO_DATASIZE,
    parameter int RD_LATENCY = RD_LAT_COMB,
    parameter int BUF_DEPTH  = 2
) (
    input  logic                rclk,
    input  logic                rrst,
    input  logic                rd_en,
    input  logic                rempty,
    input  logic [DATASIZE-1:0] rdata,
    output logic                rinc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATASIZE-1:0] out_data,
    output logic                busy
`ifdef FIFO_RD_STATS_EN
    ,
    output logic [31:0]         pop_count,
    output logic [31:0]         stall_cycles
`endif
);

    localparam int AW = $clog2(BUF_DEPTH);
    localparam int OW = AW + 1;

    logic [OW-1:0]       occ;
    logic [OW-1:0]       used, cap, free;
    logic                pop_out;
    logic                inflight_q, inflight_d;
    logic                buf_wr;
    logic [DATASIZE-1:0] buf_wdata;

    assign out_valid = (occ != '0);
    assign pop_out   = out_valid & out_ready;

    // Slots still claimable this cycle; clamps at zero instead of wrapping.
    always_comb begin
        used = occ + OW'(inflight_q);
        cap  = OW'(BUF_DEPTH) + OW'(pop_out);
        free = (cap > used) ? (cap - used) : '0;
    end

    assign rinc = ~rrst & rd_en & ~rempty & (free != '0);

    always_comb begin
        inflight_d = 1'b0;
        buf_wr     = rinc;
        buf_wdata  = rdata;
        if (RD_LATENCY == RD_LAT_REG) begin
            inflight_d = rinc;
            buf_wr     = inflight_q;
        end
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    fifo_rd_skidbuf #(
        .DATASIZE  (DATASIZE),
        .BUF_DEPTH (BUF_DEPTH)
    ) u_skidbuf (
        .clk     (rclk),
        .rst     (rrst),
        .wr_en   (buf_wr),
        .wr_data (buf_wdata),
        .rd_en   (pop_out),
        .rd_data (out_data),
        .occ     (occ)
    );

    assign busy = out_valid | inflight_q;

`ifdef FIFO_RD_STATS_EN
    logic [31:0] pop_count_q, pop_count_d;
    logic [31:0] stall_cycles_q, stall_cycles_d;

    always_comb begin
        pop_count_d    = pop_count_q;
        stall_cycles_d = stall_cycles_q;
        if (rinc && (pop_count_q != '1)) begin
            pop_count_d = pop_count_q + 32'd1;
        end
        if (out_valid && !out_ready && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            pop_count_q    <= '0;
            stall_cycles_q <= '0;
        end else begin
            pop_count_q    <= pop_count_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign pop_count    = pop_count_q;
    assign stall_cycles = stall_cycles_q;
`endif

    a_no_pop_when_empty : assert property (@(posedge rclk) rempty |-> !rinc);

    a_stall_stable : assert property (@(posedge rclk) disable iff (rrst)
        (out_valid && !out_ready) |=> $stable(out_data));

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: one instance per read latency, each fed by its own FIFO
// model, checked every cycle against a queue-level reference of the drain engine.
module tb_fifo_rd_stream;
    import fifo_pkg::*;

    localparam int NI   = 2;     // instance g uses RD_LATENCY = g
    localparam int BUFD = 2;
    localparam int FM   = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rrst      = 1'b1;
    logic       rd_en     = 1'b1;
    logic       out_ready = 1'b0;
    logic       rempty_w    [NI];
    fifo_word_t rdata_w     [NI];
    logic       rinc_w      [NI];
    logic       out_valid_w [NI];
    fifo_word_t out_data_w  [NI];
    logic       busy_w      [NI];
`ifdef FIFO_RD_STATS_EN
    logic [31:0] pc_w [NI];
    logic [31:0] sc_w [NI];
`endif

    for (genvar g = 0; g < NI; g++) begin : g_dut
        fifo_rd_stream #(
            .DATASIZE   (FIFO_DATASIZE),
            .RD_LATENCY (g),
            .BUF_DEPTH  (BUFD)
        ) u_dut (
            .rclk      (clk),
            .rrst      (rrst),
            .rd_en     (rd_en),
            .rempty    (rempty_w[g]),
            .rdata     (rdata_w[g]),
            .rinc      (rinc_w[g]),
            .out_valid (out_valid_w[g]),
            .out_ready (out_ready),
            .out_data  (out_data_w[g]),
            .busy      (busy_w[g])
`ifdef FIFO_RD_STATS_EN
            ,
            .pop_count    (pc_w[g]),
            .stall_cycles (sc_w[g])
`endif
        );
    end

    // FIFO environment: storage written by the stimulus, popped by the DUT's rinc
    fifo_word_t f_mem   [NI][FM];
    int         f_wr    [NI] = '{default: 0};
    int         f_rd    [NI] = '{default: 0};
    fifo_word_t rdata_r [NI];

    always_comb begin
        for (int g = 0; g < NI; g++) begin
            rempty_w[g] = (f_rd[g] == f_wr[g]);
            rdata_w[g]  = (g == 0) ? f_mem[g][f_rd[g] % FM] : rdata_r[g];
        end
    end

    // Reference: a queue of buffered words plus at most one word still in flight
    fifo_word_t m_q      [NI][8];
    int         m_cnt    [NI] = '{default: 0};
    logic       m_pend_v [NI] = '{default: 1'b0};
    fifo_word_t m_pend_d [NI];

    fifo_word_t deliv_d [NI][256];
    int         deliv_c [NI][256];
    int         deliv_n [NI] = '{default: 0};
    int         rinc_c  [NI][256];
    int         rinc_n  [NI] = '{default: 0};
    int         cyc = 0;

    function automatic logic exp_rinc(int g);
        int free_slots;
        if (rrst || !rd_en || (f_rd[g] == f_wr[g])) return 1'b0;
        free_slots = BUFD - m_cnt[g] - (m_pend_v[g] ? 1 : 0)
                   + (((m_cnt[g] > 0) && out_ready) ? 1 : 0);
        return free_slots > 0;
    endfunction

    always @(posedge clk) begin : p_model
        fifo_word_t q [8];
        int         n;
        logic       pv, er, ep;
        fifo_word_t pd;
        for (int g = 0; g < NI; g++) begin
            for (int k = 0; k < 8; k++) q[k] = m_q[g][k];
            n  = m_cnt[g];
            pv = m_pend_v[g];
            pd = m_pend_d[g];
            er = exp_rinc(g);
            ep = (n > 0) && out_ready;
            if (rrst) begin
                n  = 0;
                pv = 1'b0;
            end else begin
                if (ep) begin
                    for (int k = 0; k < 7; k++) q[k] = q[k+1];
                    n = n - 1;
                end
                if (pv) begin
                    q[n] = pd;
                    n    = n + 1;
                    pv   = 1'b0;
                end
                if (er) begin
                    if (g == 0) begin
                        q[n] = f_mem[g][f_rd[g] % FM];
                        n    = n + 1;
                    end else begin
                        pv = 1'b1;
                        pd = f_mem[g][f_rd[g] % FM];
                    end
                end
            end
            for (int k = 0; k < 8; k++) m_q[g][k] <= q[k];
            m_cnt[g]    <= n;
            m_pend_v[g] <= pv;
            m_pend_d[g] <= pd;

            if (rinc_w[g] === 1'b1) begin
                rdata_r[g]                 <= f_mem[g][f_rd[g] % FM];
                f_rd[g]                    <= f_rd[g] + 1;
                rinc_c[g][rinc_n[g] % 256] <= cyc;
                rinc_n[g]                  <= rinc_n[g] + 1;
            end
            if ((out_valid_w[g] === 1'b1) && out_ready && !rrst) begin
                deliv_d[g][deliv_n[g] % 256] <= out_data_w[g];
                deliv_c[g][deliv_n[g] % 256] <= cyc;
                deliv_n[g]                   <= deliv_n[g] + 1;
            end
        end
        cyc <= cyc + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input int g, input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [lat%0d] at cycle %0d: got %0h, expected %0h",
                     nm, g, cyc, act, exp);
        end
    endtask

    task automatic compare_model();
        for (int g = 0; g < NI; g++) begin
            chk(g, "rinc", 32'(rinc_w[g]), 32'(exp_rinc(g)));
            chk(g, "out_valid", 32'(out_valid_w[g]), 32'(m_cnt[g] > 0));
            chk(g, "busy", 32'(busy_w[g]), 32'((m_cnt[g] > 0) || m_pend_v[g]));
            if (m_cnt[g] > 0) chk(g, "out_data", 32'(out_data_w[g]), 32'(m_q[g][0]));
        end
    endtask

    task automatic push(input fifo_word_t w);
        for (int g = 0; g < NI; g++) begin
            f_mem[g][f_wr[g] % FM] = w;
            f_wr[g]                = f_wr[g] + 1;
        end
    endtask

    task automatic step(input logic n_rst, input logic n_en, input logic n_rdy,
                        input logic do_push, input fifo_word_t w);
        @(posedge clk);
        #1;
        rrst      = n_rst;
        rd_en     = n_en;
        out_ready = n_rdy;
        if (do_push) push(w);
        @(negedge clk);
        compare_model();
    endtask

    task automatic check_words(input int g, input string nm, input int base, input int n,
                               input int first);
        for (int i = 0; i < n; i++)
            chk(g, nm, 32'(deliv_d[g][(base + i) % 256]), 32'((first + i) & 8'hff));
    endtask

    int b_rinc [NI];
    int b_dlv  [NI];

    task automatic snap();
        for (int g = 0; g < NI; g++) begin
            b_rinc[g] = rinc_n[g];
            b_dlv[g]  = deliv_n[g];
        end
    endtask

    initial begin
        for (int i = 1; i <= 16; i++) push(fifo_word_t'(i));

        // reset held with data waiting
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0, '0);
        for (int g = 0; g < NI; g++) begin
            chk(g, "reset_out_data", 32'(out_data_w[g]), 32'h0);
            chk(g, "reset_rinc", 32'(rinc_w[g]), 32'h0);
        end

        // full-rate stream of 0x01..0x10
        snap();
        for (int i = 0; i < 25; i++) step(1'b0, 1'b1, 1'b1, 1'b0, '0);
        for (int g = 0; g < NI; g++) begin
            chk(g, "stream_pops", 32'(rinc_n[g] - b_rinc[g]), 32'd16);
            chk(g, "stream_words", 32'(deliv_n[g] - b_dlv[g]), 32'd16);
            check_words(g, "stream_order", b_dlv[g], 16, 1);
            chk(g, "stream_latency",
                32'(deliv_c[g][b_dlv[g] % 256] - rinc_c[g][b_rinc[g] % 256]), 32'(g + 1));
            chk(g, "stream_gapless",
                32'(deliv_c[g][(b_dlv[g] + 15) % 256] - deliv_c[g][b_dlv[g] % 256]), 32'd15);
            chk(g, "stream_rinc_run",
                32'(rinc_c[g][(b_rinc[g] + 15) % 256] - rinc_c[g][b_rinc[g] % 256]), 32'd15);
        end

        // downstream stall with 5 words queued
        snap();
        for (int i = 1; i <= 5; i++) step(1'b0, 1'b1, 1'b0, 1'b1, fifo_word_t'(i));
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 1'b0, '0);
        for (int g = 0; g < NI; g++) begin
            chk(g, "stall_pops", 32'(rinc_n[g] - b_rinc[g]), 32'd2);
            chk(g, "stall_head", 32'(out_data_w[g]), 32'h01);
            chk(g, "stall_valid", 32'(out_valid_w[g]), 32'h1);
        end
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1, 1'b0, '0);
        for (int g = 0; g < NI; g++) begin
            chk(g, "release_words", 32'(deliv_n[g] - b_dlv[g]), 32'd5);
            check_words(g, "release_order", b_dlv[g], 5, 1);
            chk(g, "release_gapless",
                32'(deliv_c[g][(b_dlv[g] + 4) % 256] - deliv_c[g][b_dlv[g] % 256]), 32'd4);
        end

        // rd_en dropped after three pops
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 1'b1, fifo_word_t'(8'h21 + i));
        snap();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, '0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 1'b0, '0);
        for (int g = 0; g < NI; g++) begin
            chk(g, "rden_pops", 32'(rinc_n[g] - b_rinc[g]), 32'd3);
            chk(g, "rden_words", 32'(deliv_n[g] - b_dlv[g]), 32'd3);
            check_words(g, "rden_order", b_dlv[g], 3, 8'h21);
            chk(g, "rden_busy", 32'(busy_w[g]), 32'h0);
        end

        // reset while two words are buffered
        snap();
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0, '0);
        for (int g = 0; g < NI; g++) begin
            chk(g, "prereset_head", 32'(out_data_w[g]), 32'h24);
            chk(g, "prereset_pops", 32'(rinc_n[g] - b_rinc[g]), 32'd2);
        end
        step(1'b1, 1'b1, 1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, 1'b0, '0);
        for (int g = 0; g < NI; g++) chk(g, "postreset_valid", 32'(out_valid_w[g]), 32'h0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1, 1'b0, '0);
        for (int g = 0; g < NI; g++) begin
            chk(g, "postreset_words", 32'(deliv_n[g] - b_dlv[g]), 32'd3);
            check_words(g, "postreset_order", b_dlv[g], 3, 8'h26);
            chk(g, "postreset_pops", 32'(rinc_n[g] - b_rinc[g]), 32'd5);
        end

        // randomized traffic, reset, enable and back-pressure
        for (int i = 0; i < 3000; i++) begin
            logic r, e, y, p;
            r = ($urandom_range(0, 299) == 0);
            e = ($urandom_range(0, 3) != 0);
            y = ($urandom_range(0, 2) != 0);
            p = ($urandom_range(0, 1) == 1) && ((f_wr[0] - f_rd[0]) < 200);
            step(r, e, y, p, fifo_word_t'($urandom));
        end
        for (int i = 0; i < 400; i++) step(1'b0, 1'b1, 1'b1, 1'b0, '0);
        for (int g = 0; g < NI; g++) begin
            chk(g, "drain_fifo_empty", 32'(f_wr[g] - f_rd[g]), 32'd0);
            chk(g, "drain_busy", 32'(busy_w[g]), 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
